// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants and slave receiver state encoding
package i2s_pkg;

    localparam int I2S_SLOT_BITS = 32;
    localparam int I2S_DATA_BITS = 24;

    localparam logic LRCK_LEFT = 1'b0;

    typedef enum logic [1:0] {
        HUNT,
        LEFT,
        RIGHT
    } i2s_state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// rtl/i2s_pin_sync.sv - 2-FF synchroniser for bck/lrck/din with registered bck rising-edge pulse
module i2s_pin_sync (
    input  logic sck,
    input  logic resetn,
    input  logic bck,
    input  logic lrck,
    input  logic din,
    output logic bck_rise,
    output logic lrck_s,
    output logic din_s
);

    logic [2:0] meta;
    logic [2:0] sync;
    logic       bck_prev;

    // lrck/din are re-registered alongside the edge pulse so all three stay aligned
    always_ff @(posedge sck or negedge resetn) begin
        if (!resetn) begin
            meta     <= 3'b000;
            sync     <= 3'b000;
            bck_prev <= 1'b0;
            bck_rise <= 1'b0;
            lrck_s   <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            meta     <= {din, lrck, bck};
            sync     <= meta;
            bck_prev <= sync[0];
            bck_rise <= sync[0] & ~bck_prev;
            lrck_s   <= sync[1];
            din_s    <= sync[2];
        end
    end

endmodule

// File: rtl/i2s_slave_rx.sv
// rtl/i2s_slave_rx.sv - I2S slave receiver: deserialises Philips-I2S slots into I/Q sample pairs
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int SLOT_BITS = I2S_SLOT_BITS,
    parameter int DATA_BITS = I2S_DATA_BITS,
    parameter int TIMEOUT   = 255
) (
    input  logic                 sck,
    input  logic                 resetn,
    input  logic                 bck,
    input  logic                 lrck,
    input  logic                 din,
    output logic [DATA_BITS-1:0] sample_real,
    output logic [DATA_BITS-1:0] sample_imag,
    output logic                 sample_valid,
    output logic                 frame_error,
    output logic                 locked
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [5:0]      CNT_GOOD = 6'(SLOT_BITS - 1);
    localparam logic [5:0]      CNT_DATA = 6'(DATA_BITS);
    localparam logic [5:0]      CNT_MAX  = 6'd63;
    localparam logic [WD_W-1:0] WD_FIRE  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_SAT   = WD_W'(TIMEOUT);

    logic bck_rise;
    logic lrck_s;
    logic din_s;

    i2s_pin_sync u_pin_sync (
        .sck      (sck),
        .resetn   (resetn),
        .bck      (bck),
        .lrck     (lrck),
        .din      (din),
        .bck_rise (bck_rise),
        .lrck_s   (lrck_s),
        .din_s    (din_s)
    );

    i2s_state_t           state;
    logic [5:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] left_hold;
    logic                 left_ok;
    logic                 lrck_prev;
    logic                 prev_valid;
    logic [WD_W-1:0]      wd;

    logic boundary;
    logic slot_good;

    assign boundary  = bck_rise && prev_valid && (lrck_s != lrck_prev);
    assign slot_good = (cnt == CNT_GOOD);

    always_ff @(posedge sck or negedge resetn) begin
        if (!resetn) begin
            state        <= HUNT;
            cnt          <= 6'd0;
            shreg        <= '0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            lrck_prev    <= 1'b0;
            prev_valid   <= 1'b0;
            wd           <= '0;
            sample_real  <= '0;
            sample_imag  <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;

            if (bck_rise) begin
                wd         <= '0;
                lrck_prev  <= lrck_s;
                prev_valid <= 1'b1;

                if (boundary) begin
                    cnt   <= 6'd0;
                    shreg <= '0;
                    case (state)
                        HUNT: begin
                            left_ok <= 1'b0;
                            state   <= (lrck_s == LRCK_LEFT) ? LEFT : RIGHT;
                        end
                        LEFT: begin
                            if (slot_good) begin
                                left_hold <= shreg;
                                left_ok   <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                                left_ok     <= 1'b0;
                                locked      <= 1'b0;
                            end
                            state <= RIGHT;
                        end
                        RIGHT: begin
                            // A good right slot without a good left partner is dropped silently
                            if (slot_good) begin
                                if (left_ok) begin
                                    sample_real  <= left_hold;
                                    sample_imag  <= shreg;
                                    sample_valid <= 1'b1;
                                    locked       <= 1'b1;
                                end
                            end else begin
                                frame_error <= 1'b1;
                                locked      <= 1'b0;
                            end
                            left_ok <= 1'b0;
                            state   <= LEFT;
                        end
                        default: begin
                            left_ok <= 1'b0;
                            state   <= HUNT;
                        end
                    endcase
                end else begin
                    if (cnt < CNT_DATA) begin
                        shreg <= {shreg[DATA_BITS-2:0], din_s};
                    end
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 6'd1;
                    end
                end
            end else if (wd == WD_FIRE) begin
                // A stale lrck from before the stall must not fake a boundary on restart
                wd         <= WD_SAT;
                locked     <= 1'b0;
                left_ok    <= 1'b0;
                prev_valid <= 1'b0;
                state      <= HUNT;
            end else if (wd != WD_SAT) begin
                wd <= wd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb/tb_i2s_slave_rx.sv - self-checking bench for i2s_slave_rx
module tb_i2s_slave_rx;

    logic        sck = 1'b0;
    logic        resetn;
    logic        bck;
    logic        lrck;
    logic        din;
    logic [23:0] sample_real;
    logic [23:0] sample_imag;
    logic        sample_valid;
    logic        frame_error;
    logic        locked;

    i2s_slave_rx dut (
        .sck          (sck),
        .resetn       (resetn),
        .bck          (bck),
        .lrck         (lrck),
        .din          (din),
        .sample_real  (sample_real),
        .sample_imag  (sample_imag),
        .sample_valid (sample_valid),
        .frame_error  (frame_error),
        .locked       (locked)
    );

    always #5 sck = ~sck;

    int cyc = 0;
    always @(posedge sck) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int valid_cyc = 0;
    int last_rise_cyc = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge sck) begin
        if (resetn) begin
            if (sample_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                check("valid_one_cycle", 32'(prev_v), 32'd0);
            end
            if (frame_error) begin
                err_cnt++;
                check("error_one_cycle", 32'(prev_e), 32'd0);
            end
            if (sample_valid || frame_error)
                check("valid_error_exclusive", 32'(sample_valid & frame_error), 32'd0);
        end
        prev_v = sample_valid;
        prev_e = frame_error;
    end

    // One BCK period (20 sck cycles): data/lrck change while bck is low
    task automatic bit_period(input logic l, input logic d);
        bck  = 1'b0;
        lrck = l;
        din  = d;
        #100;
        bck = 1'b1;
        last_rise_cyc = cyc;
        #100;
    endtask

    // nbits-1 bits at lrck=c, then the LSB at the switched lrck (Philips alignment)
    task automatic emit_slot(input logic c, input logic [23:0] d, input int nbits);
        logic [63:0] w;
        w = {d, 8'($urandom), 32'($urandom)};
        for (int k = 0; k < nbits - 1; k++) bit_period(c, w[63-k]);
        bit_period(~c, w[63-(nbits-1)]);
    endtask

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          lbits;
        int          rbits;
        int          exp_v;
        int          exp_e;
        logic        exp_lock;
        logic [23:0] exp_re;
        logic [23:0] exp_im;
    } vec_t;

    vec_t vt[7];

    task automatic check_frame(input string tag, input int v0, input int e0, input int exp_v,
                               input int exp_e, input logic exp_lock,
                               input logic [23:0] exp_re, input logic [23:0] exp_im);
        check({tag, " valid_count"}, 32'(valid_cnt - v0), 32'(exp_v));
        check({tag, " error_count"}, 32'(err_cnt - e0), 32'(exp_e));
        check({tag, " locked"}, 32'(locked), 32'(exp_lock));
        check({tag, " sample_real"}, 32'(sample_real), 32'(exp_re));
        check({tag, " sample_imag"}, 32'(sample_imag), 32'(exp_im));
        if (exp_v == 1)
            check({tag, " latency"}, 32'(valid_cyc - last_rise_cyc), 32'd4);
    endtask

    initial begin
        int v0;
        int e0;

        vt[0] = '{24'h7FF001, 24'h800FFE, 32, 32, 1, 0, 1'b1, 24'h7FF001, 24'h800FFE};
        vt[1] = '{24'h123456, 24'hFEDCBA, 32, 32, 1, 0, 1'b1, 24'h123456, 24'hFEDCBA};
        vt[2] = '{24'h333333, 24'hAAAAAA, 31, 32, 0, 1, 1'b0, 24'h123456, 24'hFEDCBA};
        vt[3] = '{24'h7FF001, 24'h800FFE, 32, 32, 1, 0, 1'b1, 24'h7FF001, 24'h800FFE};
        vt[4] = '{24'h555555, 24'h0F0F0F, 32, 33, 0, 1, 1'b0, 24'h7FF001, 24'h800FFE};
        vt[5] = '{24'h000001, 24'hFFFFFF, 32, 32, 1, 0, 1'b1, 24'h000001, 24'hFFFFFF};
        vt[6] = '{24'h800000, 24'h7FFFFF, 32, 32, 1, 0, 1'b1, 24'h800000, 24'h7FFFFF};

        resetn = 1'b0;
        bck    = 1'b0;
        lrck   = 1'b0;
        din    = 1'b0;
        repeat (3) @(posedge sck);
        #3;
        check("reset sample_valid", 32'(sample_valid), 32'd0);
        check("reset frame_error", 32'(frame_error), 32'd0);
        check("reset locked", 32'(locked), 32'd0);
        check("reset sample_real", 32'(sample_real), 32'd0);
        check("reset sample_imag", 32'(sample_imag), 32'd0);
        @(posedge sck);
        #3;
        resetn = 1'b1;
        @(posedge sck);
        #3;

        // Start mid-right-slot: partial slot must never be output
        v0 = valid_cnt;
        e0 = err_cnt;
        emit_slot(1'b1, 24'h9ABCDE, 10);
        check_frame("preamble", v0, e0, 0, 0, 1'b0, 24'h0, 24'h0);

        for (int i = 0; i < 7; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            emit_slot(1'b0, vt[i].l, vt[i].lbits);
            emit_slot(1'b1, vt[i].r, vt[i].rbits);
            check_frame($sformatf("row%0d", i), v0, e0, vt[i].exp_v, vt[i].exp_e,
                        vt[i].exp_lock, vt[i].exp_re, vt[i].exp_im);
        end

        // BCK stall: lock drops after the watchdog, outputs hold, no error
        v0 = valid_cnt;
        e0 = err_cnt;
        #1900;
        check("stall locked_before_timeout", 32'(locked), 32'd1);
        #1100;
        check_frame("stall", v0, e0, 0, 0, 1'b0, 24'h800000, 24'h7FFFFF);

        v0 = valid_cnt;
        e0 = err_cnt;
        emit_slot(1'b1, 24'h246813, 6);
        emit_slot(1'b0, 24'h7FF001, 32);
        emit_slot(1'b1, 24'h800FFE, 32);
        check_frame("relock", v0, e0, 1, 0, 1'b1, 24'h7FF001, 24'h800FFE);

        // Reset asserted mid-right-slot clears outputs asynchronously
        emit_slot(1'b0, 24'h111111, 32);
        for (int k = 0; k < 10; k++) bit_period(1'b1, 1'($urandom));
        #4;
        resetn = 1'b0;
        #1;
        check("async_reset locked", 32'(locked), 32'd0);
        check("async_reset sample_real", 32'(sample_real), 32'd0);
        check("async_reset sample_imag", 32'(sample_imag), 32'd0);
        check("async_reset sample_valid", 32'(sample_valid), 32'd0);
        check("async_reset frame_error", 32'(frame_error), 32'd0);
        #20;
        resetn = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        emit_slot(1'b1, 24'h222222, 22);
        check_frame("after_reset partial", v0, e0, 0, 0, 1'b0, 24'h0, 24'h0);
        v0 = valid_cnt;
        e0 = err_cnt;
        emit_slot(1'b0, 24'h0ABCDE, 32);
        emit_slot(1'b1, 24'hF54321, 32);
        check_frame("after_reset frame", v0, e0, 1, 0, 1'b1, 24'h0ABCDE, 24'hF54321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
